// File: rtl/pcie_vc_stim_checker.sv
// Stimulus generator and lock-step checker for a behavioural / synthesised multi-VC
// FIFO pair: writes one tagged burst per VC, drains every VC and reports pass/fail.
module pcie_vc_stim_checker #(
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned NUM_VC     = 2,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned TIMEOUT    = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_VC-1:0]            full_fifo,
    input  logic [NUM_VC-1:0]            full_fifo_synth,
    input  logic [NUM_VC-1:0]            empty_fifo,
    input  logic [NUM_VC-1:0]            empty_fifo_synth,
    input  logic [NUM_VC-1:0]            error_vc,
    input  logic [NUM_VC-1:0]            error_vc_synth,
    input  logic [NUM_VC*DATA_WIDTH-1:0] data_out,
    input  logic [NUM_VC*DATA_WIDTH-1:0] data_out_synth,
    output logic                         wr_enable,
    output logic [DATA_WIDTH-1:0]        data_in,
    output logic [NUM_VC-1:0]            pop,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [7:0]                   mismatch_count
);

    localparam int unsigned VC_W  = $clog2(NUM_VC);
    localparam int unsigned SEQ_W = DATA_WIDTH - VC_W;
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [VC_W-1:0]  LAST_VC  = VC_W'(NUM_VC - 1);
    localparam logic [SEQ_W-1:0] LAST_SEQ = SEQ_W'(BURST_LEN - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        POP   = 3'd2,
        DONE  = 3'd3,
        ABORT = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic [VC_W-1:0]       vc_idx;
    logic [VC_W-1:0]       vc_idx_next;
    logic [SEQ_W-1:0]      seq;
    logic [SEQ_W-1:0]      seq_next;
    logic [TO_W-1:0]       to_cnt;
    logic [TO_W-1:0]       to_cnt_next;
    logic                  err_sticky;
    logic                  err_sticky_next;
    logic                  wr_enable_next;
    logic [DATA_WIDTH-1:0] data_in_next;
    logic [NUM_VC-1:0]     pop_next;
    logic                  busy_next;
    logic                  done_next;
    logic                  pass_next;
    logic [7:0]            mismatch_next;

    logic cur_full;
    logic cur_empty;
    logic running;
    logic stalling;
    logic timed_out;
    logic diff;
    logic any_err;

    assign cur_full  = full_fifo[vc_idx];
    assign cur_empty = empty_fifo[vc_idx];
    assign running   = (state == WRITE) || (state == POP);
    // A stalled write or a pop that keeps finding data both count towards the timeout
    assign stalling  = ((state == WRITE) && cur_full) || ((state == POP) && !cur_empty);
    assign timed_out = stalling && (to_cnt == TO_LIMIT);
    assign diff      = (full_fifo != full_fifo_synth) || (empty_fifo != empty_fifo_synth) ||
                       (error_vc != error_vc_synth) || (data_out != data_out_synth);
    assign any_err   = (|error_vc) || (|error_vc_synth);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ABORT: begin
                if (start) state_next = WRITE;
            end
            WRITE: begin
                if (timed_out)
                    state_next = ABORT;
                else if (!cur_full && (seq == LAST_SEQ) && (vc_idx == LAST_VC))
                    state_next = POP;
            end
            POP: begin
                if (timed_out)
                    state_next = ABORT;
                else if (cur_empty && (vc_idx == LAST_VC))
                    state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Next values of every registered output and internal counter
    always_comb begin
        vc_idx_next     = vc_idx;
        seq_next        = seq;
        to_cnt_next     = to_cnt;
        err_sticky_next = err_sticky;
        mismatch_next   = mismatch_count;
        wr_enable_next  = 1'b0;
        data_in_next    = data_in;
        pop_next        = '0;

        case (state)
            IDLE, DONE, ABORT: begin
                if (start) begin
                    vc_idx_next     = '0;
                    seq_next        = '0;
                    to_cnt_next     = '0;
                    err_sticky_next = 1'b0;
                    mismatch_next   = 8'd0;
                end
            end
            WRITE: begin
                data_in_next = {vc_idx, seq};
                if (cur_full) begin
                    to_cnt_next = to_cnt + TO_W'(1);
                end else begin
                    wr_enable_next = 1'b1;
                    to_cnt_next    = '0;
                    if (seq == LAST_SEQ) begin
                        seq_next    = '0;
                        vc_idx_next = (vc_idx == LAST_VC) ? '0 : vc_idx + VC_W'(1);
                    end else begin
                        seq_next = seq + SEQ_W'(1);
                    end
                end
            end
            POP: begin
                if (cur_empty) begin
                    to_cnt_next = '0;
                    vc_idx_next = (vc_idx == LAST_VC) ? '0 : vc_idx + VC_W'(1);
                end else begin
                    to_cnt_next = to_cnt + TO_W'(1);
                    pop_next    = NUM_VC'(1) << vc_idx;
                end
            end
            default: ;
        endcase

        if (running) begin
            if (any_err) err_sticky_next = 1'b1;
            if (diff && (mismatch_count != 8'hFF)) mismatch_next = mismatch_count + 8'd1;
        end

        busy_next = (state_next == WRITE) || (state_next == POP);
        done_next = (state_next == DONE) || (state_next == ABORT);
        pass_next = (state_next == DONE) && (mismatch_next == 8'd0) && !err_sticky_next;

        if (done_next) begin
            wr_enable_next = 1'b0;
            pop_next       = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vc_idx         <= '0;
            seq            <= '0;
            to_cnt         <= '0;
            err_sticky     <= 1'b0;
            wr_enable      <= 1'b0;
            data_in        <= '0;
            pop            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch_count <= 8'd0;
        end else begin
            vc_idx         <= vc_idx_next;
            seq            <= seq_next;
            to_cnt         <= to_cnt_next;
            err_sticky     <= err_sticky_next;
            wr_enable      <= wr_enable_next;
            data_in        <= data_in_next;
            pop            <= pop_next;
            busy           <= busy_next;
            done           <= done_next;
            pass           <= pass_next;
            mismatch_count <= mismatch_next;
        end
    end

endmodule

// File: tb/tb_pcie_vc_stim_checker.sv
// Directed bench: default 2-VC checker driven by a FIFO-pair model, plus a 4-VC / 8-bit /
// burst-2 instance checked for write tagging and drain order.
`timescale 1ns/1ps
module tb_pcie_vc_stim_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start;
    logic start_b;

    // 2-VC instance environment
    logic [1:0]  full_fifo;
    logic [1:0]  empty_fifo;
    logic [1:0]  err_inj;
    logic [11:0] data_out;
    logic [11:0] data_out_synth;
    logic [1:0]  force_full;
    logic        stuck_empty0;
    logic        corrupt;

    logic        wr_enable;
    logic [5:0]  data_in;
    logic [1:0]  pop;
    logic        busy;
    logic        done;
    logic        pass;
    logic [7:0]  mismatch_count;

    // 4-VC instance environment
    logic [3:0]  empty_b;
    logic        wr_enable_b;
    logic [7:0]  data_in_b;
    logic [3:0]  pop_b;
    logic        busy_b;
    logic        done_b;
    logic        pass_b;
    logic [7:0]  mismatch_count_b;

    pcie_vc_stim_checker dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .full_fifo        (full_fifo),
        .full_fifo_synth  (full_fifo),
        .empty_fifo       (empty_fifo),
        .empty_fifo_synth (empty_fifo),
        .error_vc         (err_inj),
        .error_vc_synth   (err_inj),
        .data_out         (data_out),
        .data_out_synth   (data_out_synth),
        .wr_enable        (wr_enable),
        .data_in          (data_in),
        .pop              (pop),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .mismatch_count   (mismatch_count)
    );

    pcie_vc_stim_checker #(
        .DATA_WIDTH (8),
        .NUM_VC     (4),
        .BURST_LEN  (2),
        .TIMEOUT    (32)
    ) dut_b (
        .clk              (clk),
        .reset            (reset),
        .start            (start_b),
        .full_fifo        (4'b0000),
        .full_fifo_synth  (4'b0000),
        .empty_fifo       (empty_b),
        .empty_fifo_synth (empty_b),
        .error_vc         (4'b0000),
        .error_vc_synth   (4'b0000),
        .data_out         (32'h0),
        .data_out_synth   (32'h0),
        .wr_enable        (wr_enable_b),
        .data_in          (data_in_b),
        .pop              (pop_b),
        .busy             (busy_b),
        .done             (done_b),
        .pass             (pass_b),
        .mismatch_count   (mismatch_count_b)
    );

    // Ideal per-VC FIFO model shared by both DUT ports; popping an empty FIFO is ignored
    logic [5:0] mem [2][8];
    int cnt [2];
    int wp  [2];
    int rp  [2];
    int cnt_b [4];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                cnt[k] <= 0;
                wp[k]  <= 0;
                rp[k]  <= 0;
            end else begin
                if (wr_enable && (int'(data_in[5]) == k)) begin
                    mem[k][wp[k]] <= data_in;
                    wp[k] <= (wp[k] + 1) % 8;
                end
                if (pop[k] && (cnt[k] > 0)) rp[k] <= (rp[k] + 1) % 8;
                cnt[k] <= cnt[k] + ((wr_enable && (int'(data_in[5]) == k)) ? 1 : 0)
                                 - ((pop[k] && (cnt[k] > 0)) ? 1 : 0);
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (!reset) cnt_b[k] <= 0;
            else cnt_b[k] <= cnt_b[k] + ((wr_enable_b && (int'(data_in_b[7:6]) == k)) ? 1 : 0)
                                      - ((pop_b[k] && (cnt_b[k] > 0)) ? 1 : 0);
        end
    end

    always_comb begin
        full_fifo  = '0;
        empty_fifo = '0;
        data_out   = '0;
        empty_b    = '0;
        for (int k = 0; k < 2; k++) begin
            full_fifo[k]      = force_full[k] || (cnt[k] >= 8);
            empty_fifo[k]     = (cnt[k] == 0) && !((k == 0) && stuck_empty0);
            data_out[k*6 +: 6] = mem[k][rp[k]];
        end
        for (int k = 0; k < 4; k++) empty_b[k] = (cnt_b[k] == 0);
    end

    assign data_out_synth = data_out ^ {11'b0, corrupt & pop[0]};

    // Monitor: logs accepted words (with cycle stamp) and each new pop vector
    int         cyc = 0;
    logic [5:0] wlog [$];
    int         wcyc [$];
    logic [1:0] plog [$];
    logic [1:0] pop_prev = '0;
    int         pop0_n = 0;
    int         onehot_bad = 0;
    logic [7:0] wlog_b [$];
    logic [3:0] plog_b [$];
    logic [3:0] pop_prev_b = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (wr_enable) begin
            wlog.push_back(data_in);
            wcyc.push_back(cyc);
        end
        if ((pop != 2'b00) && (pop != pop_prev)) plog.push_back(pop);
        pop_prev <= pop;
        if (pop[0]) pop0_n <= pop0_n + 1;
        if (($countones(pop) > 1) || ($countones(pop_b) > 1)) onehot_bad <= onehot_bad + 1;
        if (wr_enable_b) wlog_b.push_back(data_in_b);
        if ((pop_b != 4'b0000) && (pop_b != pop_prev_b)) plog_b.push_back(pop_b);
        pop_prev_b <= pop_b;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [5:0] exp_a [8] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23};
    logic [7:0] exp_b [8] = '{8'h00, 8'h01, 8'h40, 8'h41, 8'h80, 8'h81, 8'hC0, 8'hC1};
    logic [3:0] exp_pb [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input bit on_b, input string tag);
        int i;
        i = 0;
        while ((i < 400) && !(on_b ? done_b : done)) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(on_b ? done_b : done), 32'd1);
        @(negedge clk);
    endtask

    task automatic check_burst_a(input string tag, input int base);
        check($sformatf("%s_nwords", tag), 32'(wlog.size() - base), 32'd8);
        for (int i = 0; i < 8; i++)
            if (base + i < wlog.size())
                check($sformatf("%s_word%0d", tag, i), 32'(wlog[base+i]), 32'(exp_a[i]));
    endtask

    task automatic check_pops_a(input string tag, input int pbase);
        check($sformatf("%s_npops", tag), 32'(plog.size() - pbase), 32'd2);
        if (plog.size() >= pbase + 2) begin
            check($sformatf("%s_pop_first", tag), 32'(plog[pbase]), 32'd1);
            check($sformatf("%s_pop_second", tag), 32'(plog[pbase+1]), 32'd2);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int pbase;
        int p0;
        int nb;

        reset = 1'b0; start = 1'b0; start_b = 1'b0;
        force_full = '0; stuck_empty0 = 1'b0; corrupt = 1'b0; err_inj = '0;
        repeat (3) @(negedge clk);
        check("rst_wr_enable", 32'(wr_enable), 32'd0);
        check("rst_data_in", 32'(data_in), 32'd0);
        check("rst_pop", 32'(pop), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_mismatch", 32'(mismatch_count), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Ideal run
        base = wlog.size(); pbase = plog.size();
        pulse_start();
        check("t1_busy", 32'(busy), 32'd1);
        wait_done(1'b0, "t1_done");
        check_burst_a("t1", base);
        if (wcyc.size() >= base + 8) check("t1_wr_span", 32'(wcyc[base+7] - wcyc[base] + 1), 32'd8);
        check_pops_a("t1", pbase);
        check("t1_pass", 32'(pass), 32'd1);
        check("t1_mismatch", 32'(mismatch_count), 32'd0);
        check("t1_busy_end", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        check("t1_done_held", 32'(done), 32'd1);
        check("t1_pass_held", 32'(pass), 32'd1);

        // Three-cycle full stall in the VC1 burst
        base = wlog.size();
        pulse_start();
        for (int i = 0; i < 40; i++) begin
            if (wr_enable && (data_in == 6'h20)) break;
            @(negedge clk);
        end
        check("t2_vc1_first", 32'({wr_enable, data_in}), 32'({1'b1, 6'h20}));
        force_full = 2'b10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_stall_wr", 32'(wr_enable), 32'd0);
            check("t2_stall_data", 32'(data_in), 32'h21);
        end
        force_full = 2'b00;
        @(negedge clk);
        check("t2_resume", 32'({wr_enable, data_in}), 32'({1'b1, 6'h21}));
        wait_done(1'b0, "t2_done");
        check_burst_a("t2", base);
        if (wcyc.size() >= base + 8) check("t2_wr_span", 32'(wcyc[base+7] - wcyc[base] + 1), 32'd11);
        check("t2_pass", 32'(pass), 32'd1);

        // Synth VC0 data bit 0 inverted while VC0 is popped
        corrupt = 1'b1;
        pulse_start();
        wait_done(1'b0, "t3_done");
        corrupt = 1'b0;
        check("t3_mismatch", 32'(mismatch_count), 32'd5);
        check("t3_pass", 32'(pass), 32'd0);

        // Matching error flags on both DUTs, plus a start pulse while busy
        base = wlog.size();
        pulse_start();
        repeat (2) @(negedge clk);
        err_inj = 2'b10;
        @(negedge clk);
        err_inj = 2'b00;
        pulse_start();
        wait_done(1'b0, "t5_done");
        check_burst_a("t5", base);
        check("t5_mismatch", 32'(mismatch_count), 32'd0);
        check("t5_pass", 32'(pass), 32'd0);

        // VC0 never reports empty: drain timeout
        p0 = pop0_n;
        stuck_empty0 = 1'b1;
        pulse_start();
        wait_done(1'b0, "t4_done");
        stuck_empty0 = 1'b0;
        check("t4_pop0_cycles", 32'(pop0_n - p0), 32'd31);
        check("t4_pass", 32'(pass), 32'd0);
        check("t4_pop", 32'(pop), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_mismatch", 32'(mismatch_count), 32'd0);

        // Reset mid-write, then a clean run
        pulse_start();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("t6_async_clear", 32'({wr_enable, data_in, pop, busy, done, pass, mismatch_count}), 32'd0);
        @(negedge clk);
        nb = wlog.size();
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check("t6_no_writes", 32'(wlog.size() - nb), 32'd0);
        check("t6_idle", 32'({busy, done, pop}), 32'd0);
        base = wlog.size(); pbase = plog.size();
        pulse_start();
        wait_done(1'b0, "t6_done");
        check_burst_a("t6", base);
        check_pops_a("t6", pbase);
        check("t6_pass", 32'(pass), 32'd1);

        // 4-VC, 8-bit, burst-2 instance
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_done(1'b1, "t7_done");
        check("t7_nwords", 32'(wlog_b.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            if (i < wlog_b.size()) check($sformatf("t7_word%0d", i), 32'(wlog_b[i]), 32'(exp_b[i]));
        check("t7_npops", 32'(plog_b.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < plog_b.size()) check($sformatf("t7_pop%0d", i), 32'(plog_b[i]), 32'(exp_pb[i]));
        check("t7_pass", 32'(pass_b), 32'd1);
        check("t7_mismatch", 32'(mismatch_count_b), 32'd0);

        check("pop_onehot", 32'(onehot_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
